// File: rtl/clint_tick_master.sv
// clint_tick_master: autonomous periodic tick on the CLINT timer.
// Reads mtime tear-free and re-arms mtimecmp by period on expiry.
module clint_tick_master #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                bus_req,
  input  logic                bus_gnt,
  output logic [15:0]         a,
  output logic [31:0]         d,
  output logic                we,
  input  logic [31:0]         spo,
  input  logic                t_irq,
  output logic                tick,
  output logic [31:0]         tick_cnt,
  output logic [31:0]         miss_cnt,
  output logic                armed
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RH1,
    S_RL,
    S_RH2,
    S_CALC,
    S_WCHM,
    S_WCL,
    S_WCH,
    S_WAIT,
    S_DISH,
    S_DISL
  } state_t;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [15:0] a;
    logic [31:0] d;
  } bus_t;

  localparam logic [15:0] A_CMPL = 16'h4000;
  localparam logic [15:0] A_CMPH = 16'h4004;
  localparam logic [15:0] A_MTL  = 16'hBFF8;
  localparam logic [15:0] A_MTH  = 16'hBFFC;
  localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

  function automatic logic [31:0] swap32(
    input logic [31:0] v
  );
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Bus request, address and data presented while in state s.
  function automatic bus_t bus_for(
    input state_t      s,
    input logic [63:0] c
  );
    bus_t b;
    b = '0;
    unique case (s)
      S_RH1, S_RH2: begin
        b.req = 1'b1;
        b.a   = A_MTH;
      end
      S_RL: begin
        b.req = 1'b1;
        b.a   = A_MTL;
      end
      S_WCHM, S_DISH: begin
        b.req = 1'b1;
        b.wr  = 1'b1;
        b.a   = A_CMPH;
        b.d   = ONES;
      end
      S_WCL: begin
        b.req = 1'b1;
        b.wr  = 1'b1;
        b.a   = A_CMPL;
        b.d   = swap32(c[31:0]);
      end
      S_WCH: begin
        b.req = 1'b1;
        b.wr  = 1'b1;
        b.a   = A_CMPH;
        b.d   = swap32(c[63:32]);
      end
      S_DISL: begin
        b.req = 1'b1;
        b.wr  = 1'b1;
        b.a   = A_CMPL;
        b.d   = ONES;
      end
      default: b = '0;
    endcase
    return b;
  endfunction

  state_t      r_state;
  bus_t        r_bus;
  logic [31:0] r_hi1;
  logic [31:0] r_lo;
  logic [63:0] r_cmp;
  logic        r_first;
  logic        r_tick;
  logic        r_armed;
  logic [31:0] r_tick_cnt;
  logic [31:0] r_miss_cnt;

  state_t      w_ns;
  logic        w_done;
  logic [31:0] w_rd;
  logic [63:0] w_per;
  logic [63:0] w_mtime;
  logic [63:0] w_base;
  logic [63:0] w_sum;
  logic        w_miss;
  logic [63:0] w_nxt;

  assign w_done  = r_bus.req & bus_gnt;
  assign w_rd    = swap32(spo);
  assign w_mtime = {r_hi1, r_lo};

  // Next compare value, with skip-forward when already overrun.
  always_comb begin
    w_per = 64'(period);
    if (period == '0) w_per = 64'd1;
    w_base = r_first ? w_mtime : r_cmp;
    w_sum  = w_base + w_per;
    w_miss = !r_first && (w_sum <= w_mtime);
    w_nxt  = w_miss ? w_mtime + w_per : w_sum;
  end

  // Next-state decode; bus states only move on a granted cycle.
  always_comb begin
    w_ns = r_state;
    unique case (r_state)
      S_IDLE: if (en) w_ns = S_RH1;
      S_RH1:  if (w_done) w_ns = en ? S_RL : S_DISH;
      S_RL:   if (w_done) w_ns = en ? S_RH2 : S_DISH;
      S_RH2: begin
        if (w_done) begin
          if (!en)                w_ns = S_DISH;
          else if (w_rd == r_hi1) w_ns = S_CALC;
          else                    w_ns = S_RL;
        end
      end
      S_CALC: w_ns = en ? S_WCHM : S_DISH;
      S_WCHM: if (w_done) w_ns = en ? S_WCL : S_DISH;
      S_WCL:  if (w_done) w_ns = en ? S_WCH : S_DISH;
      S_WCH:  if (w_done) w_ns = en ? S_WAIT : S_DISH;
      S_WAIT: begin
        if (!en)       w_ns = S_DISH;
        else if (t_irq) w_ns = S_RH1;
      end
      S_DISH: if (w_done) w_ns = S_DISL;
      S_DISL: if (w_done) w_ns = S_IDLE;
      default: w_ns = S_IDLE;
    endcase
  end

  // State, datapath and registered bus/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bus      <= '0;
      r_hi1      <= '0;
      r_lo       <= '0;
      r_cmp      <= '0;
      r_first    <= 1'b1;
      r_tick     <= 1'b0;
      r_armed    <= 1'b0;
      r_tick_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_ns;
      r_bus   <= bus_for(w_ns, r_cmp);
      r_armed <= (w_ns == S_WAIT);
      r_tick  <= 1'b0;
      unique case (r_state)
        S_IDLE: if (en) r_first <= 1'b1;
        S_RH1:  if (w_done) r_hi1 <= w_rd;
        S_RL:   if (w_done) r_lo <= w_rd;
        S_RH2:  if (w_done) r_hi1 <= w_rd;
        S_CALC: begin
          if (en) begin
            r_cmp   <= w_nxt;
            r_first <= 1'b0;
            if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
          end
        end
        S_WAIT: begin
          if (en && t_irq) begin
            r_tick     <= 1'b1;
            r_tick_cnt <= r_tick_cnt + 32'd1;
          end
        end
        S_DISL: if (w_done) r_first <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus_req  = r_bus.req;
  assign a        = r_bus.a;
  assign d        = r_bus.d;
  assign we       = r_bus.req & r_bus.wr & bus_gnt;
  assign tick     = r_tick;
  assign tick_cnt = r_tick_cnt;
  assign miss_cnt = r_miss_cnt;
  assign armed    = r_armed;

endmodule
